ysyx_040750_lsu_ctrl: RTL and testbench

MEM-stage load/store sequencer between the EX/MEM and MEM/WB pipeline registers. It accepts one instruction per handshake, issues a single data-memory request for loads and stores, waits for the response, and presents result data plus valid to the MEM/WB register. Non-memory instructions bypass combinationally. It drives the valid/allowin handshake on both sides, so it alone stalls the pipeline for memory latency.

---
 rtl/ysyx_040750_lsu_ctrl.sv | 162 ++++++++++++++++
 tb/tb_ysyx_040750_lsu_ctrl.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_040750_lsu_ctrl.sv
// MEM-stage load/store sequencer: one data-memory access per accepted
// load/store, with combinational bypass for non-memory instructions and
// a valid/allowin handshake toward both pipeline registers.
module ysyx_040750_lsu_ctrl #(
   parameter int P_ADDR_W  = 32,
   parameter int P_DATA_W  = 64,
   parameter int P_CNT_W   = 8,
   parameter int P_TIMEOUT = 200
) (
   input  logic                  I_sys_clk,
   input  logic                  I_rst,
   input  logic                  I_valid,
   output logic                  O_allowin,
   input  logic                  I_mem_ren,
   input  logic                  I_mem_wen,
   input  logic [P_ADDR_W-1:0]   I_addr,
   input  logic [P_DATA_W-1:0]   I_wdata,
   input  logic [P_DATA_W/8-1:0] I_wstrb,
   output logic                  O_valid,
   input  logic                  I_allowin,
   output logic [P_DATA_W-1:0]   O_mem_data,
   output logic                  O_mem_err,
   output logic                  O_req_valid,
   input  logic                  I_req_ready,
   output logic [P_ADDR_W-1:0]   O_req_addr,
   output logic                  O_req_wen,
   output logic [P_DATA_W-1:0]   O_req_wdata,
   output logic [P_DATA_W/8-1:0] O_req_wstrb,
   input  logic                  I_resp_valid,
   output logic                  O_resp_ready,
   input  logic [P_DATA_W-1:0]   I_resp_data,
   input  logic                  I_resp_err,
   output logic                  O_busy
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      WAIT = 2'd2,
      DONE = 2'd3
   } state_t;

   // Last counter value allowed in WAIT before declaring a timeout.
   localparam int                 TO_LAST_I = (P_TIMEOUT > 0) ? P_TIMEOUT - 1 : 0;
   localparam logic [P_CNT_W-1:0] TO_LAST   = P_CNT_W'(TO_LAST_I);
   localparam logic [P_CNT_W-1:0] CNT_ONE   = P_CNT_W'(1);
   localparam logic [P_CNT_W-1:0] CNT_MAX   = '1;

   state_t                  state_q, state_d;
   logic [P_ADDR_W-1:0]     addr_q, addr_d;
   logic                    wen_q, wen_d;
   logic [P_DATA_W-1:0]     wdata_q, wdata_d;
   logic [P_DATA_W/8-1:0]   wstrb_q, wstrb_d;
   logic [P_DATA_W-1:0]     data_q, data_d;
   logic                    err_q, err_d;
   logic [P_CNT_W-1:0]      cnt_q, cnt_d;

   logic mem_op;
   assign mem_op = I_mem_ren | I_mem_wen;

   // Request fields come straight from the latches, so they stay stable
   // for the whole REQ phase.
   assign O_req_addr  = addr_q;
   assign O_req_wen   = wen_q;
   assign O_req_wdata = wdata_q;
   assign O_req_wstrb = wstrb_q;
   assign O_busy      = (state_q != IDLE);

   // State and latch registers with synchronous reset.
   always_ff @(posedge I_sys_clk) begin
      if (I_rst) begin
         state_q <= IDLE;
         addr_q  <= '0;
         wen_q   <= 1'b0;
         wdata_q <= '0;
         wstrb_q <= '0;
         data_q  <= '0;
         err_q   <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         wen_q   <= wen_d;
         wdata_q <= wdata_d;
         wstrb_q <= wstrb_d;
         data_q  <= data_d;
         err_q   <= err_d;
         cnt_q   <= cnt_d;
      end
   end

   // Next-state, latch updates and handshake outputs.
   always_comb begin
      state_d      = state_q;
      addr_d       = addr_q;
      wen_d        = wen_q;
      wdata_d      = wdata_q;
      wstrb_d      = wstrb_q;
      data_d       = data_q;
      err_d        = err_q;
      cnt_d        = cnt_q;
      O_allowin    = 1'b0;
      O_valid      = 1'b0;
      O_req_valid  = 1'b0;
      O_resp_ready = 1'b0;
      O_mem_data   = '0;
      O_mem_err    = 1'b0;
      case (state_q)
         IDLE: begin
            O_allowin = mem_op ? 1'b1 : I_allowin;
            if (I_valid) begin
               if (mem_op) begin
                  // Both ren and wen set is treated as a store.
                  addr_d  = I_addr;
                  wen_d   = I_mem_wen;
                  wdata_d = I_wdata;
                  wstrb_d = I_wstrb;
                  state_d = REQ;
               end else begin
                  O_valid = 1'b1;
               end
            end
         end
         REQ: begin
            O_req_valid = 1'b1;
            if (I_req_ready) begin
               cnt_d   = '0;
               state_d = WAIT;
            end
         end
         WAIT: begin
            O_resp_ready = 1'b1;
            if (I_resp_valid) begin
               data_d  = wen_q ? '0 : I_resp_data;
               err_d   = I_resp_err;
               state_d = DONE;
            end else begin
               if (cnt_q != CNT_MAX) begin
                  cnt_d = cnt_q + CNT_ONE;
               end
               if ((P_TIMEOUT != 0) && (cnt_q == TO_LAST)) begin
                  data_d  = '0;
                  err_d   = 1'b1;
                  state_d = DONE;
               end
            end
         end
         DONE: begin
            O_valid    = 1'b1;
            O_mem_data = data_q;
            O_mem_err  = err_q;
            if (I_allowin) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_ysyx_040750_lsu_ctrl.sv
// Directed bench for the MEM-stage load/store sequencer. Two instances share
// all inputs: dut uses an 8-cycle timeout, dut0 has the timeout disabled.
module tb_ysyx_040750_lsu_ctrl;

   logic        I_sys_clk = 1'b0;
   logic        I_rst;
   logic        I_valid, I_mem_ren, I_mem_wen, I_allowin;
   logic [31:0] I_addr;
   logic [63:0] I_wdata;
   logic [7:0]  I_wstrb;
   logic        I_req_ready, I_resp_valid, I_resp_err;
   logic [63:0] I_resp_data;

   logic        O_allowin, O_valid, O_mem_err, O_req_valid, O_req_wen, O_resp_ready, O_busy;
   logic [63:0] O_mem_data, O_req_wdata;
   logic [31:0] O_req_addr;
   logic [7:0]  O_req_wstrb;

   logic        d0_allowin, d0_valid, d0_mem_err, d0_req_valid, d0_req_wen, d0_resp_ready, d0_busy;
   logic [63:0] d0_mem_data, d0_req_wdata;
   logic [31:0] d0_req_addr;
   logic [7:0]  d0_req_wstrb;

   int n_cmp  = 0;
   int n_fail = 0;

   always #5 I_sys_clk = ~I_sys_clk;

   ysyx_040750_lsu_ctrl #(.P_TIMEOUT(8)) dut (
      .I_sys_clk(I_sys_clk), .I_rst(I_rst), .I_valid(I_valid), .O_allowin(O_allowin),
      .I_mem_ren(I_mem_ren), .I_mem_wen(I_mem_wen), .I_addr(I_addr), .I_wdata(I_wdata),
      .I_wstrb(I_wstrb), .O_valid(O_valid), .I_allowin(I_allowin), .O_mem_data(O_mem_data),
      .O_mem_err(O_mem_err), .O_req_valid(O_req_valid), .I_req_ready(I_req_ready),
      .O_req_addr(O_req_addr), .O_req_wen(O_req_wen), .O_req_wdata(O_req_wdata),
      .O_req_wstrb(O_req_wstrb), .I_resp_valid(I_resp_valid), .O_resp_ready(O_resp_ready),
      .I_resp_data(I_resp_data), .I_resp_err(I_resp_err), .O_busy(O_busy)
   );

   ysyx_040750_lsu_ctrl #(.P_TIMEOUT(0)) dut0 (
      .I_sys_clk(I_sys_clk), .I_rst(I_rst), .I_valid(I_valid), .O_allowin(d0_allowin),
      .I_mem_ren(I_mem_ren), .I_mem_wen(I_mem_wen), .I_addr(I_addr), .I_wdata(I_wdata),
      .I_wstrb(I_wstrb), .O_valid(d0_valid), .I_allowin(I_allowin), .O_mem_data(d0_mem_data),
      .O_mem_err(d0_mem_err), .O_req_valid(d0_req_valid), .I_req_ready(I_req_ready),
      .O_req_addr(d0_req_addr), .O_req_wen(d0_req_wen), .O_req_wdata(d0_req_wdata),
      .O_req_wstrb(d0_req_wstrb), .I_resp_valid(I_resp_valid), .O_resp_ready(d0_resp_ready),
      .I_resp_data(I_resp_data), .I_resp_err(I_resp_err), .O_busy(d0_busy)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Advance one clock; inputs change and outputs are sampled 1-2 ns after the edge.
   task automatic tick();
      @(posedge I_sys_clk);
      #1;
   endtask

   initial begin
      I_rst = 1'b1; I_valid = 1'b0; I_mem_ren = 1'b0; I_mem_wen = 1'b0; I_allowin = 1'b1;
      I_addr = '0; I_wdata = '0; I_wstrb = '0; I_req_ready = 1'b0;
      I_resp_valid = 1'b0; I_resp_err = 1'b0; I_resp_data = '0;
      tick(); tick();
      I_rst = 1'b0;
      #1;
      // Reset state
      chk("rst_valid", O_valid, 0);
      chk("rst_busy", O_busy, 0);
      chk("rst_req_valid", O_req_valid, 0);
      chk("rst_resp_ready", O_resp_ready, 0);
      chk("rst_allowin", O_allowin, 1);
      $display("reset: valid=%0b busy=%0b", O_valid, O_busy);

      // Non-memory bypass
      tick();
      I_valid = 1'b1; I_allowin = 1'b1;
      #1;
      chk("byp_valid", O_valid, 1);
      chk("byp_allowin", O_allowin, 1);
      chk("byp_data", O_mem_data, 0);
      chk("byp_err", O_mem_err, 0);
      I_allowin = 1'b0;
      #1;
      chk("byp_allowin_bp", O_allowin, 0);
      chk("byp_valid_bp", O_valid, 1);
      tick();
      chk("byp_busy", O_busy, 0);
      $display("bypass: valid=%0b allowin(bp)=0", O_valid);
      I_valid = 1'b0; I_allowin = 1'b1;

      // Load on a zero-wait bus
      tick();
      I_valid = 1'b1; I_mem_ren = 1'b1; I_addr = 32'h8000_0010; I_req_ready = 1'b1;
      #1;
      chk("ld_allowin", O_allowin, 1);
      chk("ld_valid_idle", O_valid, 0);
      tick();
      I_valid = 1'b0; I_mem_ren = 1'b0;
      #1;
      chk("ld_req_valid", O_req_valid, 1);
      chk("ld_req_addr", O_req_addr, 64'h8000_0010);
      chk("ld_req_wen", O_req_wen, 0);
      tick();
      I_req_ready = 1'b0; I_resp_valid = 1'b1; I_resp_data = 64'h1122_3344_5566_7788;
      #1;
      chk("ld_resp_ready", O_resp_ready, 1);
      chk("ld_valid_wait", O_valid, 0);
      tick();
      I_resp_valid = 1'b0; I_resp_data = '0;
      #1;
      chk("ld_valid", O_valid, 1);
      chk("ld_data", O_mem_data, 64'h1122_3344_5566_7788);
      chk("ld_err", O_mem_err, 0);
      chk("ld_allowin_done", O_allowin, 0);
      $display("load: data=%h err=%0b", O_mem_data, O_mem_err);
      tick();
      chk("ld_idle_valid", O_valid, 0);
      chk("ld_idle_busy", O_busy, 0);

      // Store (ren and wen both set) with a 4-cycle request stall
      I_valid = 1'b1; I_mem_ren = 1'b1; I_mem_wen = 1'b1; I_addr = 32'h8000_0020;
      I_wdata = 64'hDEAD_BEEF_CAFE_F00D; I_wstrb = 8'h0F; I_req_ready = 1'b0;
      tick();
      I_valid = 1'b0; I_mem_ren = 1'b0; I_mem_wen = 1'b0;
      I_addr = 32'h0; I_wdata = 64'h5555_5555_5555_5555; I_wstrb = 8'hF0;
      for (int i = 0; i < 4; i++) begin
         #1;
         chk("st_req_valid", O_req_valid, 1);
         chk("st_req_addr", O_req_addr, 64'h8000_0020);
         chk("st_req_wdata", O_req_wdata, 64'hDEAD_BEEF_CAFE_F00D);
         chk("st_req_wstrb", O_req_wstrb, 8'h0F);
         chk("st_req_wen", O_req_wen, 1);
         tick();
      end
      I_req_ready = 1'b1;
      tick();
      I_req_ready = 1'b0; I_resp_valid = 1'b1; I_resp_data = 64'hFFFF_FFFF_FFFF_FFFF;
      #1;
      chk("st_req_dropped", O_req_valid, 0);
      tick();
      I_resp_valid = 1'b0;
      #1;
      chk("st_valid", O_valid, 1);
      chk("st_data", O_mem_data, 0);
      chk("st_err", O_mem_err, 0);
      $display("store: valid=%0b data=%h", O_valid, O_mem_data);
      tick();

      // Load with response error, then downstream backpressure in DONE
      I_valid = 1'b1; I_mem_ren = 1'b1; I_addr = 32'h8000_0030; I_req_ready = 1'b1;
      tick();
      I_valid = 1'b0; I_mem_ren = 1'b0;
      tick();
      I_req_ready = 1'b0; I_resp_valid = 1'b1; I_resp_err = 1'b1;
      I_resp_data = 64'hA5A5_0000_5A5A_1234; I_allowin = 1'b0;
      tick();
      I_resp_valid = 1'b0; I_resp_err = 1'b0; I_resp_data = '0;
      I_valid = 1'b1; I_mem_ren = 1'b1; I_addr = 32'h8000_0040;
      for (int i = 0; i < 5; i++) begin
         #1;
         chk("bp_valid", O_valid, 1);
         chk("bp_data", O_mem_data, 64'hA5A5_0000_5A5A_1234);
         chk("bp_err", O_mem_err, 1);
         chk("bp_allowin", O_allowin, 0);
         tick();
      end
      I_allowin = 1'b1;
      #1;
      chk("bp_release_allowin", O_allowin, 0);
      chk("bp_release_valid", O_valid, 1);
      tick();
      chk("bp_idle_allowin", O_allowin, 1);
      chk("bp_idle_valid", O_valid, 0);
      $display("backpressure: released, next load offered");
      tick();
      I_valid = 1'b0; I_mem_ren = 1'b0;
      #1;
      chk("bp_next_req", O_req_valid, 1);
      chk("bp_next_addr", O_req_addr, 64'h8000_0040);

      // Reset while in WAIT; a late response must be ignored
      I_req_ready = 1'b1;
      tick();
      I_req_ready = 1'b0;
      #1;
      chk("rw_resp_ready_pre", O_resp_ready, 1);
      I_rst = 1'b1;
      tick();
      I_rst = 1'b0;
      #1;
      chk("rw_busy", O_busy, 0);
      chk("rw_req_valid", O_req_valid, 0);
      chk("rw_resp_ready", O_resp_ready, 0);
      I_resp_valid = 1'b1; I_resp_data = 64'h0BAD_0BAD_0BAD_0BAD;
      tick();
      I_resp_valid = 1'b0;
      #1;
      chk("rw_late_valid", O_valid, 0);
      chk("rw_late_busy", O_busy, 0);
      $display("reset-in-wait: busy=%0b valid=%0b", O_busy, O_valid);

      // Timeout: dut (8 cycles) times out, dut0 (disabled) waits ~300 cycles
      I_valid = 1'b1; I_mem_ren = 1'b1; I_addr = 32'h8000_0050; I_req_ready = 1'b1;
      tick();
      I_valid = 1'b0; I_mem_ren = 1'b0;
      tick();
      I_req_ready = 1'b0;
      for (int i = 0; i < 8; i++) begin
         #1;
         chk("to_wait_valid", O_valid, 0);
         chk("to_wait_busy", O_busy, 1);
         tick();
      end
      #1;
      chk("to_valid", O_valid, 1);
      chk("to_err", O_mem_err, 1);
      chk("to_data", O_mem_data, 0);
      chk("to0_still_wait", d0_resp_ready, 1);
      $display("timeout8: valid=%0b err=%0b", O_valid, O_mem_err);
      repeat (292) tick();
      chk("to0_no_valid", d0_valid, 0);
      chk("to0_busy", d0_busy, 1);
      I_resp_valid = 1'b1; I_resp_data = 64'h0123_4567_89AB_CDEF;
      tick();
      I_resp_valid = 1'b0; I_resp_data = '0;
      #1;
      chk("to0_valid", d0_valid, 1);
      chk("to0_err", d0_mem_err, 0);
      chk("to0_data", d0_mem_data, 64'h0123_4567_89AB_CDEF);
      chk("to_dut_ignored", O_valid, 0);
      $display("timeout0: valid=%0b err=%0b data=%h", d0_valid, d0_mem_err, d0_mem_data);
      tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
